// File: rtl/watch_pkg.sv
// Shared types and constants for the multi-alarm clock.
package watch_pkg;

    typedef enum logic [1:0] {
        TIMER     = 2'd0,
        SET       = 2'd1,
        ALERM_SET = 2'd2
    } mode_e;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 6;

    localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;
    localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
    localparam logic [HOUR_W-1:0] MAX_HOUR = 6'd23;

    // Increment a 6-bit time field, wrapping to zero after max.
    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
        return (v == max) ? 6'd0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Key auto-repeat: one pulse right after a press, then one every SET_CNT cycles while held.
module key_repeat #(
    parameter int SET_CNT = 12_500_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic pulse_o
);

    localparam int CW = (SET_CNT > 1) ? $clog2(SET_CNT) : 1;

    logic          key_q;
    logic [CW-1:0] cnt_q;
    logic          pulse_q;

    // Edge detect plus repeat interval counter; release cancels immediately.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_q   <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            key_q <= key_i;
            if (!key_i) begin
                cnt_q   <= '0;
                pulse_q <= 1'b0;
            end else if (!key_q) begin
                cnt_q   <= '0;
                pulse_q <= 1'b1;
            end else if (cnt_q == CW'(SET_CNT - 1)) begin
                cnt_q   <= '0;
                pulse_q <= 1'b1;
            end else begin
                cnt_q   <= cnt_q + CW'(1);
                pulse_q <= 1'b0;
            end
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/multi_alarm_control.sv
// Digital clock with time-set, per-channel alarm-set, and shared-duration ringing.
module multi_alarm_control
    import watch_pkg::*;
#(
    parameter int SECOND_CNT     = 50_000_000,
    parameter int SET_CNT        = 12_500_000,
    parameter int NUM_ALERM      = 4,
    parameter int ALERM_DURATION = 60,
    localparam int SEL_W         = (NUM_ALERM > 1) ? $clog2(NUM_ALERM) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 set,
    input  logic                 alerm,
    input  logic [SEL_W-1:0]     alerm_sel,
    input  logic [NUM_ALERM-1:0] alerm_switch,
    input  logic                 minute_set,
    input  logic                 hour_set,
    input  logic                 hour_mode,
    output logic [17:0]          time_data,
    output logic                 alerm_equal,
    output logic [NUM_ALERM-1:0] alerm_active,
    output logic                 am_pm_div
);

    localparam int PS_W   = (SECOND_CNT > 1) ? $clog2(SECOND_CNT) : 1;
    localparam int RING_W = $clog2(ALERM_DURATION + 1);

    mode_e               state_q;
    logic [PS_W-1:0]     ps_q;
    logic [SEC_W-1:0]    sec_q, sec_d;
    logic [MIN_W-1:0]    min_q, min_d;
    logic [HOUR_W-1:0]   hour_q, hour_d;
    logic [MIN_W-1:0]    alm_min_q  [NUM_ALERM];
    logic [HOUR_W-1:0]   alm_hour_q [NUM_ALERM];
    logic [RING_W-1:0]   ring_q, ring_d;
    logic [NUM_ALERM-1:0] active_q, active_d, match;
    logic [17:0]         time_data_q;
    logic                am_pm_q;
    logic                min_pulse, hour_pulse, tick, roll;
    logic [HOUR_W-1:0]   src_hour, disp_hour;
    logic [MIN_W-1:0]    src_min;
    logic [SEC_W-1:0]    src_sec;

    key_repeat #(.SET_CNT(SET_CNT)) u_min_key (
        .clk_i(clock), .rst_i(reset), .key_i(minute_set), .pulse_o(min_pulse)
    );

    key_repeat #(.SET_CNT(SET_CNT)) u_hour_key (
        .clk_i(clock), .rst_i(reset), .key_i(hour_set), .pulse_o(hour_pulse)
    );

    // Mode FSM: set outranks alerm.
    always_ff @(posedge clock) begin
        if (reset)      state_q <= TIMER;
        else if (set)   state_q <= SET;
        else if (alerm) state_q <= ALERM_SET;
        else            state_q <= TIMER;
    end

    assign tick = (state_q != SET) && (ps_q == PS_W'(SECOND_CNT - 1));
    assign roll = tick && (sec_q == MAX_SEC);

    // Next time: key edits without carry in SET, carry chain on ticks otherwise.
    always_comb begin
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (state_q == SET) begin
            sec_d = '0;
            if (min_pulse)  min_d  = wrap_inc(min_q, MAX_MIN);
            if (hour_pulse) hour_d = wrap_inc(hour_q, MAX_HOUR);
        end else if (tick) begin
            sec_d = wrap_inc(sec_q, MAX_SEC);
            if (sec_q == MAX_SEC) begin
                min_d = wrap_inc(min_q, MAX_MIN);
                if (min_q == MAX_MIN) hour_d = wrap_inc(hour_q, MAX_HOUR);
            end
        end
    end

    // Time and prescaler registers; prescaler held at zero in SET.
    always_ff @(posedge clock) begin
        if (reset) begin
            ps_q   <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
        end else begin
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
            if (state_q == SET || tick) ps_q <= '0;
            else                        ps_q <= ps_q + PS_W'(1);
        end
    end

    // Alarm edits apply only to the selected, in-range channel.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_ALERM; i++) begin
                alm_min_q[i]  <= '0;
                alm_hour_q[i] <= '0;
            end
        end else if (state_q == ALERM_SET) begin
            for (int unsigned i = 0; i < NUM_ALERM; i++) begin
                if (alerm_sel == SEL_W'(i)) begin
                    if (min_pulse)  alm_min_q[i]  <= wrap_inc(alm_min_q[i], MAX_MIN);
                    if (hour_pulse) alm_hour_q[i] <= wrap_inc(alm_hour_q[i], MAX_HOUR);
                end
            end
        end
    end

    // Channel matches against the time the rolling tick is about to produce.
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < NUM_ALERM; i++) begin
            match[i] = roll && alerm_switch[i] &&
                       (hour_d == alm_hour_q[i]) && (min_d == alm_min_q[i]);
        end
    end

    // Ringing: new match reloads the shared counter; expiry clears every channel.
    always_comb begin
        active_d = active_q & alerm_switch;
        ring_d   = ring_q;
        if (state_q == SET) begin
            active_d = '0;
            ring_d   = '0;
        end else if (|match) begin
            active_d = active_d | match;
            ring_d   = RING_W'(ALERM_DURATION);
        end else if (tick && ring_q != '0) begin
            ring_d = ring_q - RING_W'(1);
            if (ring_q == RING_W'(1)) active_d = '0;
        end
    end

    // Ring state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            ring_q   <= '0;
            active_q <= '0;
        end else begin
            ring_q   <= ring_d;
            active_q <= active_d;
        end
    end

    // Display source selection and 12 h conversion.
    always_comb begin
        src_hour = hour_q;
        src_min  = min_q;
        src_sec  = sec_q;
        if (state_q == ALERM_SET) begin
            src_hour = '0;
            src_min  = '0;
            src_sec  = '0;
            for (int unsigned i = 0; i < NUM_ALERM; i++) begin
                if (alerm_sel == SEL_W'(i)) begin
                    src_hour = alm_hour_q[i];
                    src_min  = alm_min_q[i];
                end
            end
        end
        disp_hour = src_hour;
        if (hour_mode) begin
            if (src_hour == '0)          disp_hour = 6'd12;
            else if (src_hour > 6'd12)   disp_hour = src_hour - 6'd12;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            time_data_q <= '0;
            am_pm_q     <= 1'b0;
        end else begin
            time_data_q <= {disp_hour, src_min, src_sec};
            am_pm_q     <= (src_hour >= 6'd12);
        end
    end

    assign time_data    = time_data_q;
    assign am_pm_div    = am_pm_q;
    assign alerm_active = active_q;
    assign alerm_equal  = |active_q;

endmodule
